// File: rtl/ps2_pkg.sv
// Shared constants and FSM state encoding for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t IDLE   = 2'd0;
    localparam ps2_state_t DATA   = 2'd1;
    localparam ps2_state_t PARITY = 2'd2;
    localparam ps2_state_t STOP   = 2'd3;

endpackage

// File: rtl/ps2_sync_filter.sv
// 2-flop synchroniser plus a saturating level filter; emits a one-cycle pulse
// when the filtered level goes 1->0.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic fall
);

    logic [1:0] sync;
    logic       filt;
    logic       filt_d;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '1;
            filt   <= 1'b1;
            filt_d <= 1'b1;
            cnt    <= '0;
        end else begin
            sync   <= {sync[0], din};
            filt_d <= filt;
            // Any sample agreeing with the current level restarts the run.
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == 8'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign fall = filt_d & ~filt;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver presenting the latest scan code as key_reg.
// Optional macro PS2_BREAK_FILTER_EN suppresses break codes (F0 and the byte after it).
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_ack,
    output logic [7:0] key_reg,
    output logic       key_valid,
    output logic       parity_err,
    output logic       overrun
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_fall;
    logic [1:0]    data_sync;
    logic          data_s;
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          stop_fall;
    logic          frame_ok;
    logic          err_event;
    logic          accept;
    logic          deliver;
`ifdef PS2_BREAK_FILTER_EN
    logic          break_pending;
`endif

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_clk),
        .fall  (clk_fall)
    );

    assign data_s = data_sync[1];

    always_comb begin
        stop_fall = clk_fall && (state == STOP);
        frame_ok  = data_s && (^{shift, par_bit});
        err_event = stop_fall && !frame_ok;
        accept    = stop_fall && frame_ok;
        deliver   = accept;
`ifdef PS2_BREAK_FILTER_EN
        if (accept && (shift == PS2_BREAK || break_pending))
            deliver = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync  <= '1;
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            key_reg    <= '0;
            key_valid  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_sync <= {data_sync[0], ps2_data};

            if (clk_fall) begin
                case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s;
                        state   <= STOP;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
                state <= IDLE;
            end

            if (clk_fall || state == IDLE || tmo_cnt == TMO_LAST)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            if (deliver)
                key_reg <= shift;
            key_valid  <= deliver | (key_valid & ~rd_ack);
            overrun    <= (deliver & key_valid & ~rd_ack) | (overrun & ~rd_ack);
            parity_err <= err_event | (parity_err & ~rd_ack);
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    always_ff @(posedge clk) begin
        if (reset)
            break_pending <= 1'b0;
        else if (accept)
            break_pending <= (shift == PS2_BREAK);
    end
`endif

endmodule
